// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: fair rotation, one-cycle dead gap between owners.
// Define RR_GRANT_SCHED_TIMEOUT_EN to force release after HOLD_MAX grant cycles.
module rr_grant_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int HOLD_MAX = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               timeout
);

  // state | meaning
  // IDLE  | no owner, arbitrate on any request
  // GRANT | gnt_id owns the resource
  // GAP   | one dead cycle after a release, arbitrate again
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_e;

  if (HOLD_MAX < 2 || ID_W != $clog2(NUM_REQ)) begin : g_bad_param
    $error("rr_grant_scheduler: illegal NUM_REQ/ID_W/HOLD_MAX combination");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic                 any_req;
  logic                 owner_req;
  logic [ID_W-1:0]      next_ptr;
  logic [2*NUM_REQ-1:0] dbl_sh;
  logic [NUM_REQ-1:0]   rot_req;
  logic [ID_W-1:0]      off;
  logic [ID_W:0]        win_sum;
  logic [ID_W-1:0]      win_id;

  assign any_req   = |req;
  assign owner_req = req[gnt_id_q];
  assign next_ptr  = (gnt_id_q == ID_W'(NUM_REQ-1)) ? '0 : gnt_id_q + ID_W'(1);

  // Rotate requests so bit 0 is the agent at ptr, then take the lowest set bit.
  always_comb begin
    dbl_sh  = {req, req} >> ptr_q;
    rot_req = dbl_sh[NUM_REQ-1:0];
    off     = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (rot_req[i]) off = ID_W'(i);
    end
    win_sum = {1'b0, ptr_q} + {1'b0, off};
    if (win_sum >= (ID_W+1)'(NUM_REQ)) win_id = ID_W'(win_sum - (ID_W+1)'(NUM_REQ));
    else                               win_id = win_sum[ID_W-1:0];
  end

`ifdef RR_GRANT_SCHED_TIMEOUT_EN
  localparam int HCW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  logic [HCW-1:0] hold_q, hold_d;
  logic           timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    ptr_d       = ptr_q;
`ifdef RR_GRANT_SCHED_TIMEOUT_EN
    hold_d      = hold_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      ST_GRANT: begin
`ifdef RR_GRANT_SCHED_TIMEOUT_EN
        if (!owner_req || hold_q == HCW'(HOLD_MAX-1)) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = next_ptr;
          state_d     = ST_GAP;
          timeout_d   = owner_req;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
`else
        if (!owner_req) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = next_ptr;
          state_d     = ST_GAP;
        end
`endif
      end
      default: begin
        if (any_req) begin
          gnt_d       = NUM_REQ'(1) << win_id;
          gnt_valid_d = 1'b1;
          gnt_id_d    = win_id;
          state_d     = ST_GRANT;
`ifdef RR_GRANT_SCHED_TIMEOUT_EN
          hold_d      = '0;
`endif
        end else begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef RR_GRANT_SCHED_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

endmodule
